hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline forwarding logic: a hazard and forwarding controller that keeps its own shadow copy of in-flight register writers, so producer latency, forwarding depth and source-port count are no longer fixed. It sits beside the ID stage. It produces:
- the ID stall request;
- registered EX-stage forward selects;
- combinational ID-stage forward selects for early branch resolution.

The datapath muxes stay outside this block.

---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_slot_pipe.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and defaults for the hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DEF_NUM_FWD = 2;
    localparam int DEF_MAX_LAT = 2;
    localparam int DEF_REG_AW  = 5;

    // Container widths for a slot; narrower instances zero-extend into them.
    localparam int HZ_RD_W  = 8;
    localparam int HZ_LAT_W = 4;

    localparam int FSEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [HZ_RD_W-1:0]  rd;
        logic [HZ_LAT_W-1:0] lat;
    } hz_slot_t;

endpackage
`default_nettype wire

// File: rtl/hazard_slot_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hazard_slot_pipe
// Purpose  : Shadow shift register of in-flight register writers.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_slot_pipe
    import pipe_pkg::*;
#(
    parameter int NUM_FWD = DEF_NUM_FWD,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int LAT_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_hold,
    input  logic                   i_flush,
    input  logic                   i_issue,
    input  logic [REG_AW-1:0]      i_rd,
    input  logic [LAT_W-1:0]       i_lat,
    output hz_slot_t [NUM_FWD:1]   o_slots
);

    hz_slot_t [NUM_FWD:1] r_slots;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slots <= '0;
        end else if (!i_hold) begin
            r_slots[1].valid <= i_issue & ~i_flush;
            r_slots[1].rd    <= HZ_RD_W'(i_rd);
            r_slots[1].lat   <= HZ_LAT_W'(i_lat);
            // The oldest slot falls off: that writer has reached the register file.
            for (int s = 2; s <= NUM_FWD; s++) begin
                r_slots[s] <= r_slots[s-1];
            end
        end
    end

    assign o_slots = r_slots;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : ID-stage stall and EX/ID forward-select generation.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = DEF_NUM_FWD,
    parameter int MAX_LAT = DEF_MAX_LAT,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int FSEL_W  = $clog2(NUM_FWD + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]     id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          id_early,
    input  logic                          id_we,
    input  logic [REG_AW-1:0]             id_dst,
    input  logic [$clog2(MAX_LAT+1)-1:0]  id_lat,
    input  logic                          hold,
    input  logic                          flush,
    output logic                          stall,
    output logic [NUM_SRC*FSEL_W-1:0]     ex_fwd_sel,
    output logic [NUM_SRC*FSEL_W-1:0]     id_fwd_sel,
    output logic [31:0]                   stall_count
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);

    hz_slot_t [NUM_FWD:1]        w_slots;
    logic                        w_issue;
    logic                        w_stall_any;
    logic [NUM_SRC*FSEL_W-1:0]   w_ex_calc;
    logic [NUM_SRC*FSEL_W-1:0]   w_id_calc;
    logic                        w_hit;
    int                          w_hit_s;
    int                          w_hit_lat;
    logic [REG_AW-1:0]           w_src;

    logic [NUM_SRC*FSEL_W-1:0]   r_ex_fwd_sel;
    logic [31:0]                 r_stall_count;

    assign w_issue = id_valid & ~stall & id_we & (id_dst != '0);

    hazard_slot_pipe #(
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW),
        .LAT_W   (LAT_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (hold),
        .i_flush (flush),
        .i_issue (w_issue),
        .i_rd    (id_dst),
        .i_lat   (id_lat),
        .o_slots (w_slots)
    );

    always_comb begin
        w_stall_any = 1'b0;
        w_ex_calc   = {NUM_SRC{FSEL_W'(FSEL_RF)}};
        w_id_calc   = {NUM_SRC{FSEL_W'(FSEL_RF)}};
        w_hit       = 1'b0;
        w_hit_s     = 0;
        w_hit_lat   = 0;
        w_src       = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            w_src     = id_src[j*REG_AW +: REG_AW];
            w_hit     = 1'b0;
            w_hit_s   = 0;
            w_hit_lat = 0;
            // Scan oldest to youngest so the youngest matching writer wins.
            for (int s = NUM_FWD; s >= 1; s--) begin
                if (w_slots[s].valid && (w_slots[s].rd == HZ_RD_W'(w_src))) begin
                    w_hit     = 1'b1;
                    w_hit_s   = s;
                    w_hit_lat = int'(w_slots[s].lat);
                end
            end
            if (w_hit && id_src_used[j] && (w_src != '0)) begin
                if (w_hit_s < w_hit_lat) begin
                    w_stall_any = 1'b1;
                end else begin
                    w_ex_calc[j*FSEL_W +: FSEL_W] = FSEL_W'(w_hit_s);
                end
                if (id_early) begin
                    if ((w_hit_s - 1) < w_hit_lat) begin
                        w_stall_any = 1'b1;
                    end else begin
                        w_id_calc[j*FSEL_W +: FSEL_W] = FSEL_W'(w_hit_s - 1);
                    end
                end
            end
        end
    end

    assign stall      = id_valid & w_stall_any & ~rst;
    assign id_fwd_sel = rst ? '0 : w_id_calc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_fwd_sel  <= '0;
            r_stall_count <= '0;
        end else if (!hold) begin
            r_ex_fwd_sel <= (id_valid & ~stall & ~flush) ? w_ex_calc : '0;
            if (stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign ex_fwd_sel  = r_ex_fwd_sel;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard (2- and 3-deep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic        id_early;
    logic        id_we;
    logic [4:0]  id_dst;
    logic [1:0]  id_lat;
    logic        hold;
    logic        flush;

    logic        stall2, stall3;
    logic [3:0]  ex2, ex3, idf2, idf3;
    logic [31:0] cnt2, cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard #(
        .NUM_SRC (2), .NUM_FWD (2), .MAX_LAT (2), .REG_AW (5)
    ) u_dut (
        .clk (clk), .rst (rst), .id_valid (id_valid), .id_src (id_src),
        .id_src_used (id_src_used), .id_early (id_early), .id_we (id_we),
        .id_dst (id_dst), .id_lat (id_lat), .hold (hold), .flush (flush),
        .stall (stall2), .ex_fwd_sel (ex2), .id_fwd_sel (idf2),
        .stall_count (cnt2)
    );

    hazard_scoreboard #(
        .NUM_SRC (2), .NUM_FWD (3), .MAX_LAT (3), .REG_AW (5)
    ) u_dut3 (
        .clk (clk), .rst (rst), .id_valid (id_valid), .id_src (id_src),
        .id_src_used (id_src_used), .id_early (id_early), .id_we (id_we),
        .id_dst (id_dst), .id_lat (id_lat), .hold (hold), .flush (flush),
        .stall (stall3), .ex_fwd_sel (ex3), .id_fwd_sel (idf3),
        .stall_count (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic early, input logic we,
                          input logic [4:0] dst, input logic [1:0] lat);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_early    = early;
        id_we       = we;
        id_dst      = dst;
        id_lat      = lat;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 2'd1);
    endtask

    task automatic drain();
        idle();
        tick(); tick(); tick();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        set_id(1'b1, 5'd1, 5'd1, 2'b11, 1'b1, 1'b1, 5'd1, 2'd2);
        tick();
        chk("rst_stall", 32'(stall2), 32'd0);
        chk("rst_idfwd", 32'(idf2), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("reset_ex", 32'(ex2), 32'd0);
        chk("reset_cnt", cnt2, 32'd0);

        // ALU r5 then immediate use
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd5, 2'd1); #1;
        chk("alu_wr_stall", 32'(stall2), 32'd0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 2'd1); #1;
        chk("alu_use_stall", 32'(stall2), 32'd0);
        tick();
        idle(); #1;
        chk("alu_use_ex", 32'(ex2), 32'h1);
        drain();

        // Load-use on src1
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd7, 2'd2); #1;
        chk("ld_wr_stall", 32'(stall2), 32'd0);
        tick();
        set_id(1'b1, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0, 5'd0, 2'd1); #1;
        chk("ld_use_stall1", 32'(stall2), 32'd1);
        tick();
        chk("ld_use_stall2", 32'(stall2), 32'd0);
        chk("ld_use_cnt", cnt2, 32'd1);
        chk("ld_use_bubble", 32'(ex2), 32'd0);
        tick();
        idle(); #1;
        chk("ld_use_ex", 32'(ex2), 32'h8);
        drain();

        // Two writers of r3, youngest wins; r0 writer never matches
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd3, 2'd1); #1;
        tick();
        tick();
        set_id(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 1'b1, 5'd0, 2'd2); #1;
        chk("young_stall", 32'(stall2), 32'd0);
        tick();
        set_id(1'b1, 5'd0, 5'd3, 2'b11, 1'b0, 1'b0, 5'd0, 2'd1); #1;
        chk("r0_stall", 32'(stall2), 32'd0);
        chk("young_ex", 32'(ex2), 32'h1);
        tick();
        idle(); #1;
        chk("r0_ex", 32'(ex2), 32'h8);
        drain();

        // Early branch after ALU r4
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd4, 2'd1); #1;
        tick();
        set_id(1'b1, 5'd4, 5'd0, 2'b01, 1'b1, 1'b0, 5'd0, 2'd1); #1;
        chk("br_stall1", 32'(stall2), 32'd1);
        chk("br_idfwd1", 32'(idf2), 32'd0);
        tick();
        chk("br_stall2", 32'(stall2), 32'd0);
        chk("br_idfwd2", 32'(idf2), 32'h1);
        chk("br_cnt", cnt2, 32'd2);
        tick();
        idle(); #1;
        chk("br_ex", 32'(ex2), 32'h2);
        drain();

        // Hold during load-use stall, then flush with stall pending
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd2, 2'd1); #1;
        tick();
        set_id(1'b1, 5'd2, 5'd0, 2'b01, 1'b0, 1'b1, 5'd8, 2'd2); #1;
        chk("hold_ld_stall", 32'(stall2), 32'd0);
        tick();
        set_id(1'b1, 5'd0, 5'd8, 2'b10, 1'b0, 1'b0, 5'd0, 2'd1);
        hold = 1'b1; #1;
        chk("hold_pre_stall", 32'(stall2), 32'd1);
        chk("hold_pre_ex", 32'(ex2), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_stall", 32'(stall2), 32'd1);
            chk("hold_ex", 32'(ex2), 32'h1);
            chk("hold_cnt", cnt2, 32'd2);
        end
        hold = 1'b0; flush = 1'b1; #1;
        chk("flush_stall", 32'(stall2), 32'd1);
        tick();
        flush = 1'b0; #1;
        chk("flush_ex", 32'(ex2), 32'd0);
        chk("flush_cnt", cnt2, 32'd3);
        chk("flush_after_stall", 32'(stall2), 32'd0);
        tick();
        idle(); #1;
        chk("flush_issue_ex", 32'(ex2), 32'h8);
        drain();

        // Flush drops an otherwise-issuing writer
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd10, 2'd1);
        flush = 1'b1; #1;
        tick();
        flush = 1'b0;
        set_id(1'b1, 5'd10, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 2'd1); #1;
        chk("flush_drop_stall", 32'(stall2), 32'd0);
        tick();
        idle(); #1;
        chk("flush_drop_ex", 32'(ex2), 32'd0);
        drain();

        // Hold and flush together: hold wins
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd11, 2'd2); #1;
        tick();
        set_id(1'b1, 5'd11, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 2'd1);
        hold = 1'b1; flush = 1'b1; #1;
        chk("hf_stall0", 32'(stall2), 32'd1);
        tick();
        hold = 1'b0; flush = 1'b0; #1;
        chk("hf_stall1", 32'(stall2), 32'd1);
        tick();
        chk("hf_stall2", 32'(stall2), 32'd0);
        chk("hf_cnt", cnt2, 32'd4);
        tick();
        idle(); #1;
        chk("hf_ex", 32'(ex2), 32'h2);
        drain();

        // Reset asserted while stalled
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd12, 2'd2); #1;
        tick();
        set_id(1'b1, 5'd12, 5'd12, 2'b11, 1'b1, 1'b0, 5'd0, 2'd1); #1;
        chk("rmid_pre_stall", 32'(stall2), 32'd1);
        rst = 1'b1; #1;
        chk("rmid_stall", 32'(stall2), 32'd0);
        chk("rmid_idfwd", 32'(idf2), 32'd0);
        tick();
        rst = 1'b0; #1;
        chk("rmid_post_stall", 32'(stall2), 32'd0);
        chk("rmid_post_ex", 32'(ex2), 32'd0);
        chk("rmid_post_cnt", cnt2, 32'd0);

        // Three-deep instance: multiply r9 with latency 3
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd9, 2'd3); #1;
        chk("mul_wr_stall", 32'(stall3), 32'd0);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 2'd1); #1;
        chk("mul_stall1", 32'(stall3), 32'd1);
        tick();
        chk("mul_stall2", 32'(stall3), 32'd1);
        tick();
        chk("mul_stall3", 32'(stall3), 32'd0);
        chk("mul_cnt", cnt3, 32'd2);
        tick();
        idle(); #1;
        chk("mul_ex", 32'(ex3), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
